// File: rtl/serial_accum.sv
// Bit-serial two's-complement accumulator: one full-adder slice plus a carry flop,
// LSB-first, with a valid/ready result port, per-operation overflow and optional saturation.
module serial_accum #(
    parameter int unsigned W   = 12,
    parameter int unsigned CW  = 4,
    parameter int unsigned SAT = 0
) (
    input  logic         t_clk,
    input  logic         t_rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_ovf,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            ovf_q, ovf_d;

    logic            sum_bit;
    logic            carry_out;
    logic            ovf_now;
    logic [W-1:0]    shifted;
    logic [W-1:0]    resolved;

    // Single full-adder slice operating on the current LSBs.
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        shifted   = {sum_bit, a_q[W-1:1]};
        // Only meaningful on the last slice, where a_q[0]/b_q[0] are the operand MSBs.
        ovf_now   = (a_q[0] == b_q[0]) && (sum_bit != a_q[0]);
        if ((SAT != 0) && ovf_now) begin
            resolved = a_q[0] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            resolved = shifted;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = StIdle;
            acc_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        b_d     = in_data;
                        a_d     = acc_q;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    carry_d = carry_out;
                    a_d     = shifted;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    // Result is resolved on the last slice so out_valid rises W edges after accept.
                    if (cnt_q == CW'(W - 1)) begin
                        sum_d   = resolved;
                        acc_d   = resolved;
                        ovf_d   = ovf_now;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge t_clk or negedge t_rst_n) begin
        if (!t_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !clr;
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_sum   = sum_q;
        out_ovf   = ovf_q;
    end

endmodule
